// File: rtl/noc_pkg.sv
// Shared NoC packet definitions for the output collector.
// Field layout: {data, addr, dest}, dest in the low bits.
package noc_pkg;

  localparam int WIDTH_packet = 28;
  localparam int WIDTH_addr   = 3;
  localparam int WIDTH_dest   = 3;
  localparam int WIDTH        =
    WIDTH_packet + WIDTH_addr + WIDTH_dest;

  typedef struct packed {
    logic [WIDTH_packet-1:0] data;
    logic [WIDTH_addr-1:0]   addr;
    logic [WIDTH_dest-1:0]   dest;
  } noc_packet_t;

  function automatic logic [WIDTH_dest-1:0] get_dest(
    input noc_packet_t p
  );
    return p.dest;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Payload FIFO with wrap-bit pointers.
// Head entry is read straight from the storage flops.
module sync_fifo #(
  parameter int W     = 31,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) ==
                  {1'b1, {AW{1'b0}}});

  ap_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(push && full && !pop)
  );

  ap_no_underflow: assert property (
    @(posedge clk) disable iff (reset)
    !(pop && empty)
  );

endmodule

// File: rtl/output_packet_collector.sv
// Dest filter, payload queue and delivery counter
// feeding the output sink.
module output_packet_collector
  import noc_pkg::*;
#(
  parameter int WIDTH_packet = noc_pkg::WIDTH_packet,
  parameter int WIDTH_addr   = noc_pkg::WIDTH_addr,
  parameter int WIDTH_dest   = noc_pkg::WIDTH_dest,
  parameter int WIDTH        = noc_pkg::WIDTH,
  parameter int OUT_ID       = 0,
  parameter int DEPTH        = 8,
  parameter int NUM_PACKETS  = 20,
  localparam int DW = $clog2(NUM_PACKETS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_packet,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH_packet-1:0] out_data,
  output logic [WIDTH_addr-1:0]   out_src,
  output logic [7:0]              drop_count,
  output logic [DW-1:0]           delivered,
  output logic                    done
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DONE    = 1'b1;
  localparam int FW = WIDTH_addr + WIDTH_packet;

  logic [0:0]    state;
  noc_packet_t   pkt;
  logic          dest_hit;
  logic          accept;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [FW-1:0] head;

  assign pkt      = in_packet;
  assign dest_hit = (get_dest(pkt) ==
                     WIDTH_dest'(OUT_ID));
  assign done     = (state == DONE);

  assign out_valid = !empty && !done;
  assign pop       = out_valid && out_ready;

  // Drops bypass the FIFO, so only a hit waits on space.
  assign in_ready = !done &&
                    (!full || pop || !dest_hit);
  assign accept   = in_valid && in_ready;
  assign push     = accept && dest_hit;

  sync_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({pkt.addr, pkt.data}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_src  = out_valid ?
    head[FW-1:WIDTH_packet] : '0;
  assign out_data = out_valid ?
    head[WIDTH_packet-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (accept && !dest_hit &&
                 drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      delivered <= '0;
      state     <= COLLECT;
    end else if (pop) begin
      delivered <= delivered + 1'b1;
      if (delivered == DW'(NUM_PACKETS - 1))
        state <= DONE;
    end
  end

endmodule

// File: tb/tb_output_packet_collector.sv
// Directed bench for output_packet_collector.
// Inputs change and outputs are sampled on negedge.
module tb_output_packet_collector;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] in_packet;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] out_data;
  logic [2:0]  out_src;
  logic [7:0]  drop_count;
  logic [4:0]  delivered;
  logic        done;

  int n_checks;
  int n_errors;

  logic [27:0] nxt;
  logic [27:0] nin;

  output_packet_collector dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_packet  (in_packet),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .drop_count (drop_count),
    .delivered  (delivered),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [33:0] mk(
    input logic [27:0] d,
    input logic [2:0]  a,
    input logic [2:0]  t
  );
    return {d, a, t};
  endfunction

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_packet = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_delivered", delivered, 0);
    check("rst_drop", drop_count, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);

    // three in-order packets with 1-cycle latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_packet = mk(28'h1, 3'd0, 3'd0);
    @(negedge clk);
    check("t1_v1", out_valid, 1);
    check("t1_d1", out_data, 28'h1);
    in_packet = mk(28'h2, 3'd0, 3'd0);
    @(negedge clk);
    check("t1_d2", out_data, 28'h2);
    in_packet = mk(28'h3, 3'd0, 3'd0);
    @(negedge clk);
    check("t1_d3", out_data, 28'h3);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_empty", out_valid, 0);
    check("t1_deliv", delivered, 3);

    // dest mismatch is dropped
    in_valid  = 1'b1;
    in_packet = mk(28'h77, 3'd0, 3'd5);
    #1;
    check("t2_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t2_drop", drop_count, 1);
    check("t2_out_valid", out_valid, 0);
    check("t2_deliv", delivered, 3);

    // fill the FIFO with the sink stalled
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      in_packet = mk(28'h10 + 28'(i), 3'd0, 3'd0);
      #1;
      check("t3_fill_ready", in_ready, 1);
      @(negedge clk);
    end
    in_packet = mk(28'h18, 3'd0, 3'd0);
    #1;
    check("t3_full_stall", in_ready, 0);
    check("t3_head", out_data, 28'h10);
    in_packet = mk(28'h55, 3'd1, 3'd5);
    #1;
    check("t3_drop_full", in_ready, 1);
    @(negedge clk);
    check("t3_drop_cnt", drop_count, 2);
    in_packet = mk(28'h18, 3'd0, 3'd0);
    #1;
    check("t3_still_full", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("t3_push_pop", in_ready, 1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("t3_occ8", in_ready, 0);
    check("t3_head2", out_data, 28'h11);
    check("t3_deliv", delivered, 4);

    // stream until done
    out_ready = 1'b1;
    in_valid  = 1'b1;
    nxt = 28'h11;
    nin = 28'h19;
    for (int c = 0; c < 60 && !done; c++) begin
      in_packet = mk(nin, 3'd0, 3'd0);
      #1;
      if (out_valid) begin
        check("t4_order", out_data, nxt);
        nxt = nxt + 28'd1;
      end
      if (in_ready) nin = nin + 28'd1;
      @(negedge clk);
    end
    check("t4_done", done, 1);
    check("t4_deliv", delivered, 20);
    check("t4_in_ready", in_ready, 0);
    check("t4_out_valid", out_valid, 0);
    in_packet = mk(28'h21, 3'd0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    check("t4_no_accept", in_ready, 0);
    check("t4_deliv_hold", delivered, 20);
    check("t4_done_hold", done, 1);

    // reset with four entries queued
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_clr_done", done, 0);
    in_valid  = 1'b1;
    in_packet = mk(28'h1, 3'd0, 3'd6);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      in_packet = mk(28'h30 + 28'(i), 3'd0, 3'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("t5_pre_deliv", delivered, 1);
    check("t5_pre_drop", drop_count, 1);
    check("t5_pre_head", out_data, 28'h31);
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_packet = mk(28'h99, 3'd0, 3'd0);
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_deliv", delivered, 0);
    check("t5_drop", drop_count, 0);
    check("t5_in_ready", in_ready, 1);
    @(negedge clk);
    check("t5_lost", out_valid, 0);

    // bit-exact field slicing
    in_valid  = 1'b1;
    in_packet = {28'hABCDEF0, 3'b101, 3'b000};
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t6_valid", out_valid, 1);
    check("t6_src", out_src, 3'd5);
    check("t6_data", out_data, 28'hABCDEF0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
